// File: rtl/iomem_gpio_bank.sv
// Multi-channel GPIO bank on the picoramsoc iomem bus: per-channel OUT/DIR/IN
// registers plus rising/falling edge interrupts with write-1-to-clear status.
module iomem_gpio_bank #(
    parameter logic [7:0] BASE_ADDR   = 8'h03,
    parameter int         NUM_CH      = 2,
    parameter int         WIDTH       = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    iomem_valid,
    output logic                    iomem_ready,
    input  logic [3:0]              iomem_wstrb,
    input  logic [31:0]             iomem_addr,
    input  logic [31:0]             iomem_wdata,
    output logic [31:0]             iomem_rdata,
    input  logic [NUM_CH*WIDTH-1:0] gpio_in,
    output logic [NUM_CH*WIDTH-1:0] gpio_out,
    output logic [NUM_CH*WIDTH-1:0] gpio_oe,
    output logic                    irq
);

    localparam logic [2:0] OFF_OUT     = 3'd0;
    localparam logic [2:0] OFF_DIR     = 3'd1;
    localparam logic [2:0] OFF_IN      = 3'd2;
    localparam logic [2:0] OFF_RISE_EN = 3'd3;
    localparam logic [2:0] OFF_FALL_EN = 3'd4;
    localparam logic [2:0] OFF_STATUS  = 3'd5;

    // Handshake: a request is taken when valid is high, ready is low and the
    // address top byte matches BASE_ADDR. The block answers with a one-cycle
    // ready pulse on the next edge, rdata valid only while ready is high.
    // Valid is ignored while ready is high, so acknowledges are at least two
    // cycles apart; a reset mid-request drops ready and the master retries.

    logic [WIDTH-1:0] out_q     [NUM_CH];
    logic [WIDTH-1:0] dir_q     [NUM_CH];
    logic [WIDTH-1:0] rise_en_q [NUM_CH];
    logic [WIDTH-1:0] fall_en_q [NUM_CH];
    logic [WIDTH-1:0] status_q  [NUM_CH];
    logic [WIDTH-1:0] hist_q    [NUM_CH];
    logic [WIDTH-1:0] sync_q    [NUM_CH][SYNC_STAGES];

    logic [WIDTH-1:0] in_val    [NUM_CH];
    logic [WIDTH-1:0] edge_set  [NUM_CH];
    logic [WIDTH-1:0] w1c       [NUM_CH];

    logic             sel;
    logic             wr;
    logic [2:0]       ch_idx;
    logic [2:0]       reg_off;
    logic [31:0]      lane_mask;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wval;
    logic [31:0]      rd_val;
    logic             status_any;
    logic             unused_bits;

    function automatic logic [WIDTH-1:0] merge(
        input logic [WIDTH-1:0] old_v,
        input logic [WIDTH-1:0] mask,
        input logic [WIDTH-1:0] data
    );
        return (old_v & ~mask) | (data & mask);
    endfunction

    always_comb begin
        sel       = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_ADDR);
        wr        = sel && (iomem_wstrb != 4'b0000);
        ch_idx    = iomem_addr[7:5];
        reg_off   = iomem_addr[4:2];
        lane_mask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                     {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
        wmask     = lane_mask[WIDTH-1:0];
        wval      = iomem_wdata[WIDTH-1:0];
    end

    // Address bits [23:8] and [1:0] alias by design; upper data/lane bits
    // beyond WIDTH are simply not stored.
    assign unused_bits = ^{iomem_addr[23:8], iomem_addr[1:0], iomem_wdata, lane_mask};

    always_comb begin
        status_any = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            in_val[c]   = sync_q[c][SYNC_STAGES-1];
            edge_set[c] = (in_val[c] & ~hist_q[c] & rise_en_q[c])
                        | (~in_val[c] & hist_q[c] & fall_en_q[c]);
            w1c[c]      = '0;
            if (wr && (ch_idx == 3'(c)) && (reg_off == OFF_STATUS)) begin
                w1c[c] = wval & wmask;
            end
            status_any = status_any | (|status_q[c]);
        end
    end

    // Unmatched channel indices and reserved offsets fall through to zero.
    always_comb begin
        rd_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_idx == 3'(c)) begin
                case (reg_off)
                    OFF_OUT:     rd_val = 32'(out_q[c]);
                    OFF_DIR:     rd_val = 32'(dir_q[c]);
                    OFF_IN:      rd_val = 32'(in_val[c]);
                    OFF_RISE_EN: rd_val = 32'(rise_en_q[c]);
                    OFF_FALL_EN: rd_val = 32'(fall_en_q[c]);
                    OFF_STATUS:  rd_val = 32'(status_q[c]);
                    default:     rd_val = '0;
                endcase
            end
        end
    end

    always_comb begin
        gpio_out = '0;
        gpio_oe  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            gpio_out[c*WIDTH +: WIDTH] = out_q[c];
            gpio_oe[c*WIDTH +: WIDTH]  = dir_q[c];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            irq         <= 1'b0;
        end else begin
            iomem_ready <= sel;
            if (sel) begin
                iomem_rdata <= rd_val;
            end
            irq <= status_any;
        end
    end

    // History follows IN every cycle, so enabling an edge later never fires
    // on a level that was already present.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                out_q[c]     <= '0;
                dir_q[c]     <= '0;
                rise_en_q[c] <= '0;
                fall_en_q[c] <= '0;
                status_q[c]  <= '0;
                hist_q[c]    <= '0;
                for (int s = 0; s < SYNC_STAGES; s++) begin
                    sync_q[c][s] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                sync_q[c][0] <= gpio_in[c*WIDTH +: WIDTH];
                for (int s = 1; s < SYNC_STAGES; s++) begin
                    sync_q[c][s] <= sync_q[c][s-1];
                end
                hist_q[c] <= in_val[c];
                if (wr && (ch_idx == 3'(c))) begin
                    case (reg_off)
                        OFF_OUT:     out_q[c]     <= merge(out_q[c], wmask, wval);
                        OFF_DIR:     dir_q[c]     <= merge(dir_q[c], wmask, wval);
                        OFF_RISE_EN: rise_en_q[c] <= merge(rise_en_q[c], wmask, wval);
                        OFF_FALL_EN: fall_en_q[c] <= merge(fall_en_q[c], wmask, wval);
                        default:     ;
                    endcase
                end
                // A new edge wins over a simultaneous clear of the same bit.
                status_q[c] <= (status_q[c] & ~w1c[c]) | edge_set[c];
            end
        end
    end

endmodule

// File: tb/tb_iomem_gpio_bank.sv
// Bench for iomem_gpio_bank: directed scenarios plus randomized bus/pin
// traffic checked against a delay-line reference model.
module tb_iomem_gpio_bank;

    localparam logic [7:0] BASE   = 8'h03;
    localparam int         NUM_CH = 2;
    localparam int         WIDTH  = 16;
    localparam int         SYNC   = 2;
    localparam int         TOTAL  = NUM_CH * WIDTH;

    logic             clk = 1'b0;
    logic             reset;
    logic             iomem_valid;
    logic             iomem_ready;
    logic [3:0]       iomem_wstrb;
    logic [31:0]      iomem_addr;
    logic [31:0]      iomem_wdata;
    logic [31:0]      iomem_rdata;
    logic [TOTAL-1:0] gpio_in;
    logic [TOTAL-1:0] gpio_out;
    logic [TOTAL-1:0] gpio_oe;
    logic             irq;

    always #5 clk = ~clk;

    iomem_gpio_bank #(
        .BASE_ADDR(BASE), .NUM_CH(NUM_CH), .WIDTH(WIDTH), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .reset(reset),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: registers as plain arrays, IN as a delay line of pin samples.
    logic [WIDTH-1:0] m_out [NUM_CH];
    logic [WIDTH-1:0] m_dir [NUM_CH];
    logic [WIDTH-1:0] m_ren [NUM_CH];
    logic [WIDTH-1:0] m_fen [NUM_CH];
    logic [WIDTH-1:0] m_stat[NUM_CH];
    logic [WIDTH-1:0] m_hist[NUM_CH];
    logic [TOTAL-1:0] m_pipe[$];
    logic             m_ready;
    logic             m_irq;
    logic [31:0]      exp_q[$];
    logic [31:0]      last_rdata;

    function automatic logic [WIDTH-1:0] m_in(input int c);
        logic [TOTAL-1:0] v;
        v = m_pipe[0];
        return v[c*WIDTH +: WIDTH];
    endfunction

    function automatic logic [31:0] m_read(input int ch, input int off);
        if (ch >= NUM_CH) return 32'h0;
        case (off)
            0: return 32'(m_out[ch]);
            1: return 32'(m_dir[ch]);
            2: return 32'(m_in(ch));
            3: return 32'(m_ren[ch]);
            4: return 32'(m_fen[ch]);
            5: return 32'(m_stat[ch]);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_out[c] = '0; m_dir[c] = '0; m_ren[c] = '0;
            m_fen[c] = '0; m_stat[c] = '0; m_hist[c] = '0;
        end
        m_pipe.delete();
        for (int s = 0; s < SYNC; s++) m_pipe.push_back('0);
        m_ready = 1'b0;
        m_irq   = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        int ch, off;
        bit sel, any_stat;
        logic [31:0] bm;
        logic [WIDTH-1:0] m, d, in_c, ev, clr;
        ch  = int'(iomem_addr[7:5]);
        off = int'(iomem_addr[4:2]);
        sel = iomem_valid && !m_ready && (iomem_addr[31:24] == BASE);
        bm  = 32'h0;
        for (int b = 0; b < 4; b++) if (iomem_wstrb[b]) bm[b*8 +: 8] = 8'hFF;
        m = bm[WIDTH-1:0];
        d = iomem_wdata[WIDTH-1:0];
        any_stat = 0;
        for (int c = 0; c < NUM_CH; c++) if (m_stat[c] != 0) any_stat = 1;
        if (sel) exp_q.push_back(m_read(ch, off));
        for (int c = 0; c < NUM_CH; c++) begin
            in_c = m_in(c);
            ev   = (in_c & ~m_hist[c] & m_ren[c]) | (~in_c & m_hist[c] & m_fen[c]);
            clr  = '0;
            if (sel && iomem_wstrb != 0 && ch == c) begin
                case (off)
                    0: m_out[c] = (m_out[c] & ~m) | (d & m);
                    1: m_dir[c] = (m_dir[c] & ~m) | (d & m);
                    3: m_ren[c] = (m_ren[c] & ~m) | (d & m);
                    4: m_fen[c] = (m_fen[c] & ~m) | (d & m);
                    5: clr = d & m;
                    default: ;
                endcase
            end
            m_stat[c] = (m_stat[c] & ~clr) | ev;
            m_hist[c] = in_c;
        end
        m_pipe.push_back(gpio_in);
        void'(m_pipe.pop_front());
        m_irq   = any_stat;
        m_ready = sel;
    endtask

    task automatic step();
        logic [TOTAL-1:0] exp_out, exp_oe;
        if (!reset) model_edge();
        @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) begin
            exp_out[c*WIDTH +: WIDTH] = m_out[c];
            exp_oe[c*WIDTH +: WIDTH]  = m_dir[c];
        end
        check_val("ready", iomem_ready, m_ready);
        check_val("irq", irq, m_irq);
        check_val("gpio_out", gpio_out, exp_out);
        check_val("gpio_oe", gpio_oe, exp_oe);
        if (iomem_ready) begin
            last_rdata = iomem_rdata;
            if (exp_q.size() == 0) check_val("ready_without_request", iomem_ready, 1'b0);
            else check_val("rdata", iomem_rdata, exp_q.pop_front());
        end
    endtask

    task automatic bus_xfer(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                            input bit expect_ack);
        int waited;
        iomem_addr = a; iomem_wstrb = s; iomem_wdata = d; iomem_valid = 1'b1;
        step();
        waited = 1;
        while (!iomem_ready && waited < 6) begin
            step();
            waited++;
        end
        if (expect_ack) check_val("ack_latency", waited, 1);
        else check_val("no_ack", iomem_ready, 1'b0);
        iomem_valid = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; iomem_valid = 1'b0; iomem_wstrb = '0;
        iomem_addr = '0; iomem_wdata = '0; gpio_in = '0; last_rdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check_val("rst_ready", iomem_ready, 1'b0);
        check_val("rst_rdata", iomem_rdata, 32'h0);
        check_val("rst_irq", irq, 1'b0);
        check_val("rst_gpio_out", gpio_out, '0);
        check_val("rst_gpio_oe", gpio_oe, '0);
        bus_xfer(32'h0300_0000, 4'h0, 32'h0, 1);
        check_val("rst_out_rd", last_rdata, 32'h0);

        // Byte-laned write, width truncation
        bus_xfer(32'h0300_0020, 4'b0001, 32'h0000_A5A5, 1);
        check_val("ch1_out_pins", gpio_out[31:16], 16'h00A5);
        bus_xfer(32'h0300_0020, 4'h0, 32'h0, 1);
        check_val("ch1_out_rd", last_rdata, 32'h0000_00A5);
        bus_xfer(32'h0300_0020, 4'hF, 32'hFFFF_FFFF, 1);
        bus_xfer(32'h0300_0020, 4'h0, 32'h0, 1);
        check_val("ch1_out_full", last_rdata, 32'h0000_FFFF);
        bus_xfer(32'h03AB_CD23, 4'h0, 32'h0, 1);
        check_val("alias_rd", last_rdata, 32'h0000_FFFF);
        bus_xfer(32'h0300_0024, 4'b1000, 32'hFFFF_FFFF, 1);
        bus_xfer(32'h0300_0024, 4'h0, 32'h0, 1);
        check_val("upper_lane_noop", last_rdata, 32'h0);

        // Synchroniser latency and rise detection
        gpio_in = 32'h0000_0008;
        bus_xfer(32'h0300_0008, 4'h0, 32'h0, 1);
        check_val("in_early", last_rdata, 32'h0);
        bus_xfer(32'h0300_0008, 4'h0, 32'h0, 1);
        check_val("in_visible", last_rdata, 32'h8);
        bus_xfer(32'h0300_0014, 4'h0, 32'h0, 1);
        check_val("status_disabled", last_rdata, 32'h0);
        gpio_in = '0;
        repeat (4) step();
        bus_xfer(32'h0300_000C, 4'hF, 32'h0000_0008, 1);
        gpio_in = 32'h0000_0008;
        repeat (5) step();
        bus_xfer(32'h0300_0014, 4'h0, 32'h0, 1);
        check_val("status_rise", last_rdata, 32'h8);
        check_val("irq_rise", irq, 1'b1);

        // Set beats simultaneous clear, then clean clear
        gpio_in = '0;
        repeat (4) step();
        gpio_in = 32'h0000_0008;
        step(); step();
        bus_xfer(32'h0300_0014, 4'hF, 32'h0000_0008, 1);
        bus_xfer(32'h0300_0014, 4'h0, 32'h0, 1);
        check_val("set_wins", last_rdata, 32'h8);
        bus_xfer(32'h0300_0014, 4'hF, 32'h0000_0008, 1);
        check_val("irq_cleared", irq, 1'b0);
        bus_xfer(32'h0300_0014, 4'h0, 32'h0, 1);
        check_val("status_cleared", last_rdata, 32'h0);

        // Reserved offset, absent channel, foreign address
        bus_xfer(32'h0300_0018, 4'hF, 32'hFFFF_FFFF, 1);
        bus_xfer(32'h0300_0018, 4'h0, 32'h0, 1);
        check_val("reserved_rd", last_rdata, 32'h0);
        bus_xfer(32'h0300_0040, 4'hF, 32'hFFFF_FFFF, 1);
        bus_xfer(32'h0300_0040, 4'h0, 32'h0, 1);
        check_val("absent_ch_rd", last_rdata, 32'h0);
        bus_xfer(32'h0400_0000, 4'hF, 32'hFFFF_FFFF, 0);

        // Valid held across the acknowledge: next ack must wait a cycle
        iomem_addr = 32'h0300_0020; iomem_wstrb = 4'h0; iomem_valid = 1'b1;
        step(); step(); step();
        iomem_valid = 1'b0;
        step();

        // Reset in the middle of a write
        iomem_addr = 32'h0300_0000; iomem_wstrb = 4'hF; iomem_wdata = 32'h1234; iomem_valid = 1'b1;
        step();
        #2 reset = 1'b1;
        #1;
        check_val("midrst_ready", iomem_ready, 1'b0);
        check_val("midrst_out", gpio_out, '0);
        check_val("midrst_irq", irq, 1'b0);
        model_reset();
        iomem_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        bus_xfer(32'h0300_0000, 4'h0, 32'h0, 1);
        check_val("post_rst_rd", last_rdata, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [7:0] base;
            logic [3:0] strb;
            if ($urandom_range(0, 2) == 0) gpio_in = TOTAL'($urandom);
            else if ($urandom_range(0, 1) == 0) gpio_in[$urandom_range(0, TOTAL-1)] ^= 1'b1;
            base = ($urandom_range(0, 9) == 0) ? 8'h7F : BASE;
            strb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            bus_xfer({base, 16'($urandom), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                      2'($urandom_range(0, 3))}, strb, $urandom, base == BASE);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
